// File: rtl/regfile_dumper.sv
// regfile_dumper
// Streams the contents of a register file out over a byte-wide valid/ready
// link as one frame: a header byte, every register as four bytes (most
// significant byte first, register 0 first), then an XOR checksum of the
// data bytes. Registers are read through a combinational debug probe.

module regfile_dumper #(
    parameter logic [7:0] HEADER   = 8'hA5,
    parameter int         NUM_REGS = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic [4:0]  rf_ra,
    input  logic [31:0] rf_rd,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic        busy,
    output logic        done
);

    // The parameter HEADER takes the plain name, so the states carry a prefix.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HEADER,
        ST_LOAD,
        ST_SEND,
        ST_CKSUM
    } state_t;

    localparam logic [4:0] LAST_IDX = 5'(NUM_REGS - 1);

    state_t      state;
    state_t      next_state;
    logic [4:0]  idx;
    logic [1:0]  byte_cnt;
    logic [31:0] word;
    logic [7:0]  cksum;
    logic        xfer;

    assign rf_ra = idx;
    assign busy  = (state != ST_IDLE);
    assign xfer  = tx_valid && tx_ready;

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic and the byte offered to the transmitter.
    always_comb begin
        next_state = state;
        tx_valid   = 1'b0;
        tx_data    = 8'h00;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_HEADER;
                end
            end
            ST_HEADER: begin
                tx_valid = 1'b1;
                tx_data  = HEADER;
                if (tx_ready) begin
                    next_state = ST_LOAD;
                end
            end
            ST_LOAD: begin
                next_state = ST_SEND;
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                case (byte_cnt)
                    2'd0:    tx_data = word[31:24];
                    2'd1:    tx_data = word[23:16];
                    2'd2:    tx_data = word[15:8];
                    default: tx_data = word[7:0];
                endcase
                if (tx_ready && byte_cnt == 2'd3) begin
                    next_state = (idx == LAST_IDX) ? ST_CKSUM : ST_LOAD;
                end
            end
            ST_CKSUM: begin
                tx_valid = 1'b1;
                tx_data  = cksum;
                if (tx_ready) begin
                    next_state = ST_IDLE;
                end
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Datapath: register index, byte counter, captured word, checksum, done pulse.
    always_ff @(posedge clock) begin
        if (reset) begin
            idx      <= 5'd0;
            byte_cnt <= 2'd0;
            word     <= 32'd0;
            cksum    <= 8'h00;
            done     <= 1'b0;
        end else begin
            done <= (state == ST_CKSUM) && xfer;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        idx   <= 5'd0;
                        cksum <= 8'h00;
                    end
                end
                ST_LOAD: begin
                    word     <= rf_rd;
                    byte_cnt <= 2'd0;
                end
                ST_SEND: begin
                    if (xfer) begin
                        cksum    <= cksum ^ tx_data;
                        byte_cnt <= byte_cnt + 2'd1;
                        if (byte_cnt == 2'd3 && idx != LAST_IDX) begin
                            idx <= idx + 5'd1;
                        end
                    end
                end
                ST_CKSUM: begin
                    if (xfer) begin
                        idx <= 5'd0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule
